control_sequencer: RTL and testbench



---
 rtl/control_sequencer_if.sv | 13 +
 rtl/control_sequencer.sv | 74 +++++++
 tb/tb_control_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: step/opcode/flag inputs and control-word/status outputs of the sequencer
// slave modport is the sequencer side; master modport is the driver/observer side.
interface control_sequencer_if;
  logic        step_en;
  logic [3:0]  opcode;
  logic        cf;
  logic        zf;
  logic [14:0] control_signals;
  logic [2:0]  t_state;
  logic        halted;
  modport slave (input step_en, opcode, cf, zf, output control_signals, t_state, halted);
  modport master (output step_en, opcode, cf, zf, input control_signals, t_state, halted);
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: SAP-style microcode sequencer emitting a 15-bit control word per T-state
// Ports: clk, rst (sync, active-high), bus (slave: step_en, opcode, cf, zf in; control_signals, t_state, halted out).
// SEQ_EARLY_END_EN: when defined, instructions return to T0 right after their last step;
// otherwise every instruction runs T0..T5 (HLT still halts at T2).
module control_sequencer #(
  parameter int          NUM_T    = 6,
  parameter logic [14:0] NOP_WORD = 15'h0FE3
) (
  input logic               clk,
  input logic               rst,
  control_sequencer_if.slave bus
);
  localparam logic [2:0] T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4;
  localparam logic [2:0] T5 = 3'(NUM_T - 1);
  // Strobe masks: asserting a strobe flips its bit away from the idle word.
  localparam logic [14:0] CP = 15'h4000, EP = 15'h2000, LP = 15'h1000, LMA = 15'h0800,
                          LMD = 15'h0400, CE = 15'h0200, LR = 15'h0100, LI = 15'h0080,
                          EI = 15'h0040, LA = 15'h0020, EA = 15'h0010, SUB = 15'h0008,
                          EU = 15'h0004, LB = 15'h0002, LO = 15'h0001;
  logic [2:0]  t_q, t_d, last_t;
  logic        halted_q, halted_d, hlt, adv;
  logic [14:0] act;
  always_comb begin
    act = '0;
    case (t_q)
      T0: act = EP | LMA;
      T1: act = CE | LI | CP;
      T2: case (bus.opcode)
        4'h1, 4'h2, 4'h3, 4'h4: act = EI | LMA;
        4'h5: act = EI | LA;
        4'h6: act = EI | LP;
        4'h7: act = bus.cf ? (EI | LP) : '0;
        4'h8: act = bus.zf ? (EI | LP) : '0;
        4'hE: act = EA | LO;
        default: act = '0;
      endcase
      T3: case (bus.opcode)
        4'h1: act = CE | LA;
        4'h2, 4'h3: act = CE | LB;
        4'h4: act = EA | LMD;
        default: act = '0;
      endcase
      T4: case (bus.opcode)
        4'h2: act = EU | LA;
        4'h3: act = EU | LA | SUB;
        4'h4: act = LR;
        default: act = '0;
      endcase
      default: act = '0;
    endcase
  end
`ifdef SEQ_EARLY_END_EN
  assign last_t = (bus.opcode == 4'h1) ? T3 : (bus.opcode inside {4'h2, 4'h3, 4'h4}) ? T4 : T2;
`else
  assign last_t = T5;
`endif
  assign hlt      = (t_q == T2) && (bus.opcode == 4'hF);
  assign adv      = bus.step_en && !halted_q;
  // >= guards against an opcode change mid-instruction shortening the last step.
  assign t_d      = !adv ? t_q : (hlt || t_q >= last_t || t_q == T5) ? T0 : t_q + 3'd1;
  assign halted_d = halted_q | (adv & hlt);
  always_ff @(posedge clk) begin
    if (rst) begin
      t_q      <= T0;
      halted_q <= 1'b0;
    end else begin
      t_q      <= t_d;
      halted_q <= halted_d;
    end
  end
  assign bus.control_signals = (rst || halted_q || !bus.step_en) ? NOP_WORD : NOP_WORD ^ act;
  assign bus.t_state         = t_q;
  assign bus.halted          = halted_q;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed self-checking bench for control_sequencer
module tb_control_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;
  control_sequencer_if bus ();
  control_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  localparam logic [14:0] NOP = 15'h0FE3;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask
  task automatic fetch(input logic [3:0] op);
    chk("t0_word", bus.control_signals, 15'h27E3);
    chk("t0_state", 15'(bus.t_state), 15'd0);
    bus.opcode = op;
    tick;
    chk("t1_word", bus.control_signals, 15'h4D63);
    tick;
    chk("t2_state", 15'(bus.t_state), 15'd2);
  endtask
  task automatic tail(input int last);
`ifdef SEQ_EARLY_END_EN
    tick;
`else
    for (int i = last + 1; i <= 5; i++) begin
      tick;
      chk("tail_nop", bus.control_signals, NOP);
      chk("tail_state", 15'(bus.t_state), 15'(i));
    end
    tick;
`endif
    chk("back_t0", 15'(bus.t_state), 15'd0);
  endtask
  initial begin
    rst = 1'b1;
    bus.step_en = 1'b1;
    bus.opcode = 4'h0;
    bus.cf = 1'b0;
    bus.zf = 1'b0;
    tick;
    tick;
    chk("rst_word", bus.control_signals, NOP);
    chk("rst_state", 15'(bus.t_state), 15'd0);
    chk("rst_halted", 15'(bus.halted), 15'd0);
    rst = 1'b0;
    #1;
    fetch(4'h2);
    chk("add_t2", bus.control_signals, 15'h07A3);
    tick; chk("add_t3", bus.control_signals, 15'h0DE1);
    tick; chk("add_t4", bus.control_signals, 15'h0FC7);
    tail(4);
    fetch(4'h3);
    chk("sub_t2", bus.control_signals, 15'h07A3);
    tick; chk("sub_t3", bus.control_signals, 15'h0DE1);
    tick; chk("sub_t4", bus.control_signals, 15'h0FCF);
    tail(4);
    bus.cf = 1'b1;
    fetch(4'h7); chk("jc_taken", bus.control_signals, 15'h1FA3); tail(2);
    bus.cf = 1'b0;
    fetch(4'h7); chk("jc_not", bus.control_signals, NOP); tail(2);
    bus.zf = 1'b1;
    fetch(4'h8); chk("jz_taken", bus.control_signals, 15'h1FA3); tail(2);
    bus.zf = 1'b0;
    fetch(4'h8); chk("jz_not", bus.control_signals, NOP); tail(2);
    fetch(4'h1);
    chk("lda_t2", bus.control_signals, 15'h07A3);
    tick; chk("lda_t3", bus.control_signals, 15'h0DC3);
    tail(3);
    fetch(4'h5); chk("ldi_t2", bus.control_signals, 15'h0F83); tail(2);
    fetch(4'h6); chk("jmp_t2", bus.control_signals, 15'h1FA3); tail(2);
    fetch(4'hE); chk("out_t2", bus.control_signals, 15'h0FF2); tail(2);
    fetch(4'h0); chk("nop_t2", bus.control_signals, NOP); tail(2);
    fetch(4'h9); chk("op9_t2", bus.control_signals, NOP); tail(2);
    fetch(4'h4);
    chk("sta_t2", bus.control_signals, 15'h07A3);
    tick; chk("sta_t3", bus.control_signals, 15'h0BF3);
    bus.step_en = 1'b0;
    #1;
    chk("pause_word", bus.control_signals, NOP);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("pause_word", bus.control_signals, NOP);
      chk("pause_state", 15'(bus.t_state), 15'd3);
    end
    bus.step_en = 1'b1;
    #1;
    chk("resume_t3", bus.control_signals, 15'h0BF3);
    tick; chk("sta_t4", bus.control_signals, 15'h0EE3);
    tail(4);
    fetch(4'h2);
    tick; chk("abort_t3", bus.control_signals, 15'h0DE1);
    rst = 1'b1;
    #1;
    chk("abort_rst_word", bus.control_signals, NOP);
    tick;
    chk("abort_state", 15'(bus.t_state), 15'd0);
    chk("abort_no_eu", bus.control_signals, NOP);
    rst = 1'b0;
    #1;
    fetch(4'hF);
    chk("hlt_t2", bus.control_signals, NOP);
    chk("hlt_pre", 15'(bus.halted), 15'd0);
    tick;
    chk("hlt_set", 15'(bus.halted), 15'd1);
    chk("hlt_state", 15'(bus.t_state), 15'd0);
    for (int i = 0; i < 20; i++) begin
      bus.step_en = i[0];
      tick;
      chk("hlt_word", bus.control_signals, NOP);
      chk("hlt_hold", 15'(bus.t_state), 15'd0);
      chk("hlt_sticky", 15'(bus.halted), 15'd1);
    end
    bus.step_en = 1'b1;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("hlt_clear", 15'(bus.halted), 15'd0);
    fetch(4'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
